// File: rtl/color_frame_scheduler.sv
// Colour measurement sequencer: waits for a camera frame, captures it into
// the frame RAM, runs the recognizer on it and reports the colour.
module color_frame_scheduler #(
  parameter int ADDR_W          = 15,
  parameter int BYTES_PER_FRAME = 19200,
  parameter int TO_W            = 20,
  parameter int TIMEOUT         = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_abort,
  input  logic              i_vsync,
  input  logic              i_cam_we,
  input  logic [ADDR_W-1:0] i_cam_addr,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_done,
  input  logic [7:0]        i_rec_color,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_rec_enable,
  output logic [7:0]        o_color,
  output logic              o_valid,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [7:0]        o_frames
);

  localparam int CNT_W = $clog2(BYTES_PER_FRAME + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_ANA,
    S_REP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             vsync_q;
  logic [CNT_W-1:0] byte_q;
  logic [TO_W-1:0]  to_q;
  logic [7:0]       color_q;
  logic [7:0]       frames_q;
  logic             tmo_q;

  logic vsync_rise;
  logic last_byte;
  logic to_hit;
  logic active;
  logic arm;
  logic tmo_fire;

  assign vsync_rise = i_vsync & ~vsync_q;
  assign active     = (state_q == S_WAIT) |
                      (state_q == S_CAP)  |
                      (state_q == S_ANA);
  assign to_hit     = (to_q == TO_W'(TIMEOUT));
  assign arm        = (state_q == S_IDLE) &
                      (i_start | i_continuous);
  assign last_byte  = (state_q == S_CAP) & i_cam_we &
                      (byte_q == CNT_W'(BYTES_PER_FRAME - 1));

  // done and the final byte both outrank an expiring timer
  assign tmo_fire = ~i_abort & to_hit &
                    ((state_q == S_WAIT) |
                     ((state_q == S_CAP) & ~last_byte) |
                     ((state_q == S_ANA) & ~i_rec_done));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start | i_continuous)
            state_d = S_WAIT;
        end
        S_WAIT: begin
          if (to_hit)
            state_d = S_IDLE;
          else if (vsync_rise)
            state_d = S_CAP;
        end
        S_CAP: begin
          if (last_byte)
            state_d = S_ANA;
          else if (to_hit)
            state_d = S_IDLE;
        end
        S_ANA: begin
          if (i_rec_done)
            state_d = S_REP;
          else if (to_hit)
            state_d = S_IDLE;
        end
        S_REP: begin
          state_d = i_continuous ? S_WAIT : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q  <= 1'b0;
      byte_q   <= '0;
      to_q     <= '0;
      color_q  <= '0;
      frames_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      tmo_q   <= tmo_fire;

      if (arm || state_q == S_REP)
        to_q <= '0;
      else if (active && !to_hit)
        to_q <= to_q + 1'b1;

      // a vsync edge mid-capture means the frame was short: restart
      if (state_q == S_WAIT && vsync_rise) begin
        byte_q <= '0;
      end else if (state_q == S_CAP) begin
        if (vsync_rise && !last_byte)
          byte_q <= '0;
        else if (i_cam_we)
          byte_q <= byte_q + 1'b1;
      end

      if (state_q == S_ANA && i_rec_done && !i_abort)
        color_q <= i_rec_color;

      if (state_q == S_REP && !i_abort)
        frames_q <= frames_q + 1'b1;
    end
  end

  always_comb begin
    o_ram_we     = 1'b0;
    o_ram_addr   = '0;
    o_rec_enable = 1'b0;
    o_valid      = 1'b0;
    o_busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_CAP: begin
        o_ram_we   = i_cam_we;
        o_ram_addr = i_cam_addr;
      end
      S_ANA: begin
        o_ram_addr   = i_rec_addr;
        o_rec_enable = 1'b1;
      end
      S_REP: begin
        o_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_color   = color_q;
  assign o_frames  = frames_q;
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_color_frame_scheduler.sv
// Bench for color_frame_scheduler: a full-size instance for frame-length
// scenarios and a small-frame instance for timeout, continuous and random runs.
module tb_color_frame_scheduler;

  localparam int FULL_BPF = 19200;
  localparam int FULL_TO  = 60000;
  localparam int SM_BPF   = 64;
  localparam int SM_TO    = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        abort = 1'b0;
  logic        vsync = 1'b0;
  logic        cam_we = 1'b0;
  logic [14:0] cam_addr = '0;
  logic [14:0] rec_addr = '0;
  logic        rec_done = 1'b0;
  logic [7:0]  rec_color = '0;

  logic        f_ram_we, s_ram_we;
  logic [14:0] f_ram_addr, s_ram_addr;
  logic        f_rec_enable, s_rec_enable;
  logic [7:0]  f_color, s_color;
  logic        f_valid, s_valid;
  logic        f_timeout, s_timeout;
  logic        f_busy, s_busy;
  logic [7:0]  f_frames, s_frames;

  int checks = 0;
  int failures = 0;

  bit mon = 1'b0;
  int mon_valid = 0;
  int mon_idle = 0;

  always #5 clk = ~clk;

  color_frame_scheduler #(
    .ADDR_W(15), .BYTES_PER_FRAME(FULL_BPF),
    .TO_W(20), .TIMEOUT(FULL_TO)
  ) u_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_continuous(cont), .i_abort(abort), .i_vsync(vsync),
    .i_cam_we(cam_we), .i_cam_addr(cam_addr),
    .i_rec_addr(rec_addr), .i_rec_done(rec_done),
    .i_rec_color(rec_color), .o_ram_we(f_ram_we),
    .o_ram_addr(f_ram_addr), .o_rec_enable(f_rec_enable),
    .o_color(f_color), .o_valid(f_valid),
    .o_timeout(f_timeout), .o_busy(f_busy),
    .o_frames(f_frames)
  );

  color_frame_scheduler #(
    .ADDR_W(15), .BYTES_PER_FRAME(SM_BPF),
    .TO_W(20), .TIMEOUT(SM_TO)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_continuous(cont), .i_abort(abort), .i_vsync(vsync),
    .i_cam_we(cam_we), .i_cam_addr(cam_addr),
    .i_rec_addr(rec_addr), .i_rec_done(rec_done),
    .i_rec_color(rec_color), .o_ram_we(s_ram_we),
    .o_ram_addr(s_ram_addr), .o_rec_enable(s_rec_enable),
    .o_color(s_color), .o_valid(s_valid),
    .o_timeout(s_timeout), .o_busy(s_busy),
    .o_frames(s_frames)
  );

  always @(negedge clk) begin
    if (mon) begin
      if (s_valid) mon_valid++;
      if (!s_busy) mon_idle++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; cont = 0; abort = 0; vsync = 0;
    cam_we = 0; cam_addr = '0; rec_addr = '0;
    rec_done = 0; rec_color = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [35:0] fv, sv;
    do_reset();
    @(negedge clk);
    fv = {f_ram_we, f_ram_addr, f_rec_enable, f_color,
          f_valid, f_timeout, f_busy, f_frames};
    sv = {s_ram_we, s_ram_addr, s_rec_enable, s_color,
          s_valid, s_timeout, s_busy, s_frames};
    checks++;
    if (fv !== 36'h0) begin
      failures++;
      $display("FAIL reset_full: got %h want 0", fv);
    end
    checks++;
    if (sv !== 36'h0) begin
      failures++;
      $display("FAIL reset_small: got %h want 0", sv);
    end
    tick();
  endtask

  task automatic test_capture();
    int bad = 0;
    start = 1;
    tick();
    start = 0;
    checks++;
    if (f_busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy: got %b want 1", f_busy);
    end
    vsync = 1;
    tick();
    vsync = 0;
    for (int i = 0; i < FULL_BPF; i++) begin
      cam_we = 1;
      cam_addr = 15'(i);
      @(negedge clk);
      if (f_ram_we !== 1'b1 || f_ram_addr !== cam_addr ||
          f_rec_enable !== 1'b0)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL capture_passthru: got %0d bad cycles want 0", bad);
    end
    cam_we = 1;
    cam_addr = 15'h0007;
    rec_addr = 15'h1234;
    @(negedge clk);
    checks++;
    if ({f_rec_enable, f_ram_we, f_ram_addr} !== {1'b1, 1'b0, 15'h1234}) begin
      failures++;
      $display("FAIL analyze_entry: got en=%b we=%b addr=%h want 1 0 1234",
               f_rec_enable, f_ram_we, f_ram_addr);
    end
    cam_we = 0;
  endtask

  task automatic test_report();
    rec_color = 8'h02;
    rec_done = 1;
    tick();
    rec_done = 0;
    rec_color = 8'h55;
    @(negedge clk);
    checks++;
    if (f_valid !== 1'b1 || f_color !== 8'h02) begin
      failures++;
      $display("FAIL report_pulse: got valid=%b color=%h want 1 02",
               f_valid, f_color);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({f_valid, f_frames, f_busy, f_color} !== {1'b0, 8'd1, 1'b0, 8'h02}) begin
      failures++;
      $display("FAIL report_after: got valid=%b frames=%0d busy=%b color=%h want 0 1 0 02",
               f_valid, f_frames, f_busy, f_color);
    end
    rec_color = 8'h09;
    rec_done = 1;
    tick();
    rec_done = 0;
    @(negedge clk);
    checks++;
    if (f_color !== 8'h02 || f_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_in_idle: got color=%h valid=%b want 02 0",
               f_color, f_valid);
    end
  endtask

  task automatic test_short_frame();
    int bad = 0;
    int n = 0;
    start = 1;
    tick();
    start = 0;
    vsync = 1;
    tick();
    vsync = 0;
    cam_we = 1;
    repeat (500) tick();
    cam_we = 0;
    vsync = 1;
    tick();
    vsync = 0;
    while (n < FULL_BPF - 1) begin
      cam_we = ($urandom_range(0, 7) != 0);
      cam_addr = 15'($urandom);
      rec_addr = 15'($urandom);
      @(negedge clk);
      if (f_ram_we !== cam_we || f_ram_addr !== cam_addr ||
          f_rec_enable !== 1'b0)
        bad++;
      tick();
      if (cam_we) n++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL short_frame_track: got %0d bad cycles want 0", bad);
    end
    cam_we = 1;
    tick();
    cam_we = 0;
    @(negedge clk);
    checks++;
    if (f_rec_enable !== 1'b1) begin
      failures++;
      $display("FAIL short_frame_end: got en=%b want 1", f_rec_enable);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (f_busy !== 1'b0 || f_frames !== 8'd1) begin
      failures++;
      $display("FAIL short_frame_abort: got busy=%b frames=%0d want 0 1",
               f_busy, f_frames);
    end
  endtask

  task automatic test_timeout();
    int seen = 0;
    do_reset();
    start = 1;
    tick();
    start = 0;
    vsync = 1;
    tick();
    vsync = 0;
    cam_we = 1;
    repeat (SM_BPF) tick();
    cam_we = 0;
    rec_color = 8'h03;
    rec_done = 1;
    tick();
    rec_done = 0;
    tick();
    checks++;
    if (s_frames !== 8'd1 || s_color !== 8'h03) begin
      failures++;
      $display("FAIL timeout_setup: got frames=%0d color=%h want 1 03",
               s_frames, s_color);
    end
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (s_timeout === 1'b1) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen != SM_TO + 1) begin
      failures++;
      $display("FAIL timeout_cycle: got %0d want %0d", seen, SM_TO + 1);
    end
    checks++;
    if ({s_busy, s_valid, s_frames, s_color} !== {1'b0, 1'b0, 8'd1, 8'h03}) begin
      failures++;
      $display("FAIL timeout_state: got busy=%b valid=%b frames=%0d color=%h want 0 0 1 03",
               s_busy, s_valid, s_frames, s_color);
    end
    tick();
    checks++;
    if (s_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_len: got %b want 0", s_timeout);
    end
    // done arrives on the very edge the timer expires
    start = 1;
    tick();
    start = 0;
    vsync = 1;
    tick();
    vsync = 0;
    cam_we = 1;
    repeat (SM_BPF) tick();
    cam_we = 0;
    repeat (SM_TO - SM_BPF - 1) tick();
    rec_color = 8'h01;
    rec_done = 1;
    tick();
    rec_done = 0;
    checks++;
    if ({s_valid, s_timeout, s_color} !== {1'b1, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL done_vs_timeout: got valid=%b tmo=%b color=%h want 1 0 01",
               s_valid, s_timeout, s_color);
    end
    tick();
  endtask

  task automatic test_continuous();
    do_reset();
    cont = 1;
    tick();
    mon_valid = 0;
    mon_idle = 0;
    mon = 1;
    for (int f = 0; f < 3; f++) begin
      vsync = 1;
      tick();
      vsync = 0;
      for (int b = 0; b < SM_BPF; b++) begin
        cam_we = 1;
        if (f == 1 && b == SM_BPF - 1) vsync = 1;
        tick();
        vsync = 0;
      end
      cam_we = 0;
      checks++;
      if (s_rec_enable !== 1'b1) begin
        failures++;
        $display("FAIL cont_frame%0d_analyze: got %b want 1", f, s_rec_enable);
      end
      repeat ($urandom_range(0, 5)) tick();
      rec_color = 8'h04;
      rec_done = 1;
      tick();
      rec_done = 0;
      tick();
    end
    tick();
    mon = 0;
    checks++;
    if (mon_valid != 3 || mon_idle != 0) begin
      failures++;
      $display("FAIL cont_pulses: got valid=%0d idle=%0d want 3 0",
               mon_valid, mon_idle);
    end
    checks++;
    if (s_frames !== 8'd3 || s_color !== 8'h04 || s_busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_final: got frames=%0d color=%h busy=%b want 3 04 1",
               s_frames, s_color, s_busy);
    end
    cont = 0;
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_abort_reset();
    start = 1;
    tick();
    start = 0;
    vsync = 1;
    tick();
    vsync = 0;
    cam_we = 1;
    repeat (10) tick();
    abort = 1;
    @(negedge clk);
    checks++;
    if (s_ram_we !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got we=%b want 1", s_ram_we);
    end
    tick();
    abort = 0;
    @(negedge clk);
    checks++;
    if ({s_ram_we, s_busy, s_valid, s_timeout, s_frames} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL abort_capture: got we=%b busy=%b valid=%b tmo=%b frames=%0d want 0 0 0 0 3",
               s_ram_we, s_busy, s_valid, s_timeout, s_frames);
    end
    cam_we = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    vsync = 1;
    tick();
    vsync = 0;
    cam_we = 1;
    repeat (SM_BPF) tick();
    @(negedge clk);
    checks++;
    if (s_rec_enable !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: got en=%b want 1", s_rec_enable);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({s_rec_enable, s_ram_we, s_busy, s_frames, s_color} !==
        {1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_analyze: got en=%b we=%b busy=%b frames=%0d color=%h want 0 0 0 0 00",
               s_rec_enable, s_ram_we, s_busy, s_frames, s_color);
    end
    cam_we = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    int ph = 0;
    int nb = 0;
    int tc = 0;
    int fr = 0;
    int pre = 0;
    bit pv = 0;
    bit tp = 0;
    bit rise;
    logic [7:0] col = '0;
    logic [35:0] expv, actv;
    logic [14:0] ea;
    do_reset();
    for (int cyc = 0; cyc < 4000 && failures < 20; cyc++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) cont = ~cont;
      abort = ($urandom_range(0, 255) == 0);
      vsync = ($urandom_range(0, 99) == 0);
      cam_we = ($urandom_range(0, 3) != 0);
      cam_addr = 15'($urandom);
      rec_addr = 15'($urandom);
      rec_done = ($urandom_range(0, 15) == 0);
      rec_color = 8'($urandom);
      @(negedge clk);
      ea = (ph == 2) ? cam_addr : (ph == 3) ? rec_addr : 15'h0;
      expv = {ph != 0, ph == 4, ph == 3, (ph == 2) && cam_we,
              ea, col, 8'(fr), tp};
      actv = {s_busy, s_valid, s_rec_enable, s_ram_we,
              s_ram_addr, s_color, s_frames, s_timeout};
      checks++;
      if (actv !== expv) begin
        failures++;
        $display("FAIL random_cyc%0d: got %h want %h", cyc, actv, expv);
      end
      @(posedge clk);
      rise = vsync && !pv;
      pre = ph;
      tp = 0;
      if (abort) begin
        ph = 0;
      end else if (ph == 0) begin
        if (start || cont) begin
          ph = 1;
          tc = 0;
        end
      end else if (ph == 1) begin
        if (tc == SM_TO) begin
          ph = 0; tp = 1;
        end else if (rise) begin
          ph = 2; nb = 0;
        end
      end else if (ph == 2) begin
        if (cam_we && nb == SM_BPF - 1) ph = 3;
        else if (tc == SM_TO) begin
          ph = 0; tp = 1;
        end else if (rise) nb = 0;
        else if (cam_we) nb++;
      end else if (ph == 3) begin
        if (rec_done) begin
          col = rec_color; ph = 4;
        end else if (tc == SM_TO) begin
          ph = 0; tp = 1;
        end
      end else begin
        fr = (fr + 1) % 256;
        ph = cont ? 1 : 0;
        tc = 0;
      end
      if (!abort && pre >= 1 && pre <= 3 && tc < SM_TO) tc++;
      pv = vsync;
      #1;
    end
    abort = 0;
    cont = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_report();
    test_short_frame();
    test_timeout();
    test_continuous();
    test_abort_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
